// File: rtl/sr04_scheduler.sv
// Arbitrates btn/uart/auto measurement requests for an SR04 ranging controller.
// Optional macro SR04_AVG_EN: deliver the mean of the new and previous sample.
module sr04_scheduler #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned PERIOD_MS  = 100,
    parameter int unsigned TIMEOUT_MS = 30,
    parameter int unsigned GUARD_MS   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auto_en,
    input  logic       btn_req,
    input  logic       uart_req,
    output logic       start,
    input  logic       dist_done,
    input  logic [9:0] dist_data,
    output logic [9:0] dist_out,
    output logic       dist_valid,
    output logic [1:0] owner,
    output logic       timeout_err,
    output logic       busy
);

    localparam int unsigned PRESC_MAX = CLK_HZ / 1000 - 1;
    localparam int unsigned PW   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int unsigned PDW  = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
    localparam int unsigned TMAX = (TIMEOUT_MS > GUARD_MS) ? TIMEOUT_MS : GUARD_MS;
    localparam int unsigned TMW  = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0]  PRESC_LAST   = PW'(PRESC_MAX);
    localparam logic [PDW-1:0] PERIOD_LAST  = PDW'(PERIOD_MS - 1);
    localparam logic [TMW-1:0] TIMEOUT_LAST = TMW'(TIMEOUT_MS - 1);
    localparam logic [TMW-1:0] GUARD_LAST   = TMW'(GUARD_MS - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StTrig  = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StGuard = 2'd3;

    logic [PW-1:0]  presc_q;
    logic [PDW-1:0] period_q;
    logic [TMW-1:0] timer_q, timer_d;
    logic [1:0]     state_q, state_d;
    logic [2:0]     pend_q, pend_d;   // bit 0 btn, bit 1 uart, bit 2 auto
    logic [2:0]     req_all;
    logic [1:0]     owner_q, owner_d;
    logic [9:0]     dout_q, dout_new;
    logic           valid_q, valid_d;
    logic           tout_q, tout_d;
    logic           deliver;
    logic           tick;
    logic           auto_req;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    assign auto_req = auto_en && tick && (period_q == PERIOD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
        end else if (!auto_en) begin
            period_q <= '0;
        end else if (tick) begin
            period_q <= (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
        end
    end

    // Requests arriving this cycle are visible to the IDLE grant immediately.
    assign req_all = pend_q | {auto_req, uart_req, btn_req};

    always_comb begin
        state_d = state_q;
        pend_d  = req_all;
        owner_d = owner_q;
        timer_d = timer_q;
        valid_d = 1'b0;
        tout_d  = 1'b0;
        deliver = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req_all) begin
                    state_d = StTrig;
                    if (req_all[0]) begin
                        owner_d   = 2'd1;
                        pend_d[0] = 1'b0;
                    end else if (req_all[1]) begin
                        owner_d   = 2'd2;
                        pend_d[1] = 1'b0;
                    end else begin
                        owner_d   = 2'd0;
                        pend_d[2] = 1'b0;
                    end
                end
            end
            StTrig: begin
                state_d = StWait;
                timer_d = '0;
            end
            StWait: begin
                if (dist_done) begin
                    deliver = 1'b1;
                    valid_d = 1'b1;
                    state_d = StGuard;
                    timer_d = '0;
                end else if (tick) begin
                    if (timer_q == TIMEOUT_LAST) begin
                        tout_d  = 1'b1;
                        state_d = StGuard;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (timer_q == GUARD_LAST) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef SR04_AVG_EN
    logic [9:0]  hist_q;
    logic        hist_vld_q;
    logic [10:0] sum;

    assign sum      = {1'b0, dist_data} + {1'b0, hist_q};
    assign dout_new = hist_vld_q ? 10'(sum >> 1) : dist_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
        end else if (deliver) begin
            hist_q     <= dist_data;
            hist_vld_q <= 1'b1;
        end
    end
`else
    assign dout_new = dist_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pend_q  <= '0;
            owner_q <= '0;
            timer_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            tout_q  <= tout_d;
            if (deliver) begin
                dout_q <= dout_new;
            end
        end
    end

    assign start       = (state_q == StTrig);
    assign busy        = (state_q != StIdle);
    assign dist_out    = dout_q;
    assign dist_valid  = valid_q;
    assign timeout_err = tout_q;
    assign owner       = owner_q;

endmodule
